washer_plant_model: RTL
=======================

Name: washer_plant_model

Overview:
- Synthesizable behavioural model of the washing-machine plant: water tub, heater, drum and door lock.
- It is the responder to the main controller. It consumes the actuator outputs (water_valve, heater, drain_pump, drum_motor, door_lock) and produces the sensor inputs the controller reads (water_level_sensor, temperature_adc_sensor, vibration_sensor, door_locked).
- Closes the loop for FPGA demos and controller regression without hand-written sensor waveforms.

Parameters:
- TICK_DIV, 2: clk cycles per plant update tick.
- FILL_RATE, 25: level units added per tick with valve open.
- DRAIN_RATE, 40: level units removed per tick with pump on.
- LEVEL_MAX, 1000: level saturation ceiling (10-bit).
- AMBIENT_TEMP, 20: reset/cool-down temperature.
- HEAT_STEP, 1: degrees gained per tick while heating.
- COOL_DIV, 4: ticks per 1-degree cool-down step.
- MIN_HEAT_LEVEL, 100: minimum level for heater to be effective.
- SPIN_THRESH, 8: drum_motor code at or above which the drum counts as spinning.
- RAMP_TICKS, 3: spinning ticks before an imbalance produces vibration.
- DOOR_TICKS, 2: ticks for the lock actuator to settle.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- water_valve  input  1  fill valve command
- heater  input  1  heater command
- drain_pump  input  1  drain pump command
- drum_motor  input  4  drum speed code
- door_lock  input  1  door lock command
- imbalance_load  input  1  test control: load is unbalanced
- fault_no_water  input  1  test control: supply dead, valve has no effect
- fault_clog  input  1  test control: drain blocked, pump has no effect
- water_level_sensor  output  10  tub level
- temperature_adc_sensor  output  7  water temperature
- vibration_sensor  output  1  excessive vibration
- door_locked  output  1  lock confirmed
- overflow_flag  output  1  sticky: fill requested at LEVEL_MAX
- dry_heat_flag  output  1  sticky: heater on below MIN_HEAT_LEVEL

Behaviour:
- Reset (reset=0, async, any time including mid-fill or mid-spin):
  - level=0, temperature=AMBIENT_TEMP, vibration=0, door_locked=0, both flags=0.
  - Tick counter, cool counter, ramp counter and door counter all cleared.
  - Vibration FSM forced to V_IDLE.
- Tick: counter 0..TICK_DIV-1. tick=1 when the counter is at TICK_DIV-1, so the first tick falls TICK_DIV cycles after reset release.
- Updates: all state updates only on tick cycles. Outputs are registered and change on the tick edge.
- Inputs: sampled at the tick edge. No handshake; the commands are levels.
- Level arithmetic:
  - inflow = FILL_RATE if water_valve and not fault_no_water, else 0.
  - outflow = DRAIN_RATE if drain_pump and not fault_clog, else 0.
  - next level = level + inflow - outflow, computed in 12-bit signed.
  - Clamped to 0..LEVEL_MAX; never wraps.
  - Valve and pump both on: the net rate applies.
- overflow_flag: set when water_valve=1 at a tick with level==LEVEL_MAX. Cleared only by reset.
- Temperature:
  - heater=1 and level>=MIN_HEAT_LEVEL: +HEAT_STEP per tick, saturating at 127. Cool counter held at 0.
  - Otherwise: cool counter counts ticks. Each COOL_DIV ticks, temperature steps 1 toward AMBIENT_TEMP and stops there.
  - heater=1 with level<MIN_HEAT_LEVEL: no heating, and dry_heat_flag is set (sticky).
- Vibration FSM, states V_IDLE, V_RAMP, V_SHAKE. spinning = (drum_motor>=SPIN_THRESH) and imbalance_load, evaluated at tick.
  - V_IDLE: if spinning, go to V_RAMP and set the ramp counter to 1.
  - V_RAMP: if spinning, increment the ramp counter; on reaching RAMP_TICKS go to V_SHAKE. If not spinning, go to V_IDLE.
  - V_SHAKE: vibration_sensor=1. If not spinning, go to V_IDLE and clear vibration_sensor at the same tick.
  - vibration_sensor=0 in all other states.
- Door:
  - When door_lock differs from door_locked, the door counter counts ticks. After DOOR_TICKS ticks, door_locked takes the door_lock value.
  - If the command reverts before completion, the counter clears and no change occurs.
  - door_lock=0 while level>0: still unlocks (plant models no interlock; that is the controller's job).

Optional Feature:
- PLANT_NOISE_EN defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every tick.
  - water_level_sensor = internal level + {-1, 0, 0, +1}, selected by LFSR[1:0], clamped to 0..LEVEL_MAX.
  - The internal level, overflow logic and heating threshold use the noiseless value.
- PLANT_NOISE_EN undefined: no LFSR logic; water_level_sensor equals the internal level exactly.

Test Plan:
- Fill and saturate: valve=1 only. After 20 ticks (40 clk), level=500. After 40 ticks, level=1000. One tick later, overflow_flag=1 and level stays 1000.
- Net flow and no wrap:
  - From level 500, valve=1 and pump=1: level=350 after 10 ticks.
  - Pump only from level 30: level=0 after 1 tick and stays 0.
  - fault_clog=1 with pump=1: level frozen.
- Heating and cooling:
  - level=0, heater=1: temperature stays 20 and dry_heat_flag=1.
  - level=300, heater=1 for 20 ticks: temperature=40.
  - Then heater=0: temperature=39 after 4 ticks.
- Vibration:
  - imbalance_load=1, drum_motor=10: vibration_sensor=1 at the 3rd tick.
  - drum_motor=4: vibration_sensor=0 at the next tick.
  - imbalance_load=0 with drum_motor=15: vibration_sensor never asserts.
- Door: door_lock 0->1 gives door_locked=1 after 2 ticks. A 1-tick door_lock pulse leaves door_locked=0.
- Reset mid-operation: assert reset during a fill at level 300 with temperature 35 and vibration=1. All outputs return to 0/20/0 immediately, without waiting for clk.

Source files
------------

// File: rtl/washer_plant_model.sv
// Purpose : behavioural washing-machine plant (tub level, heater, drum vibration, door lock)
//           that answers the controller's actuator commands with sensor readings.
// Latency : state advances once per plant tick (every TICK_DIV clk); outputs registered on the tick edge.
// Backpressure: none; commands are levels sampled at each tick, sensors are always valid.
//
// Ports:
//   clk, reset (async, active-low)
//   water_valve, heater, drain_pump, drum_motor[3:0], door_lock  -- actuator commands
//   imbalance_load, fault_no_water, fault_clog                   -- test controls
//   water_level_sensor[9:0], temperature_adc_sensor[6:0],
//   vibration_sensor, door_locked                                -- sensor readings
//   overflow_flag, dry_heat_flag                                 -- sticky diagnostics
//
// Optional macro PLANT_NOISE_EN: adds +/-1 LFSR dither to water_level_sensor only.
module washer_plant_model #(
    parameter int TICK_DIV       = 2,
    parameter int FILL_RATE      = 25,
    parameter int DRAIN_RATE     = 40,
    parameter int LEVEL_MAX      = 1000,
    parameter int AMBIENT_TEMP   = 20,
    parameter int HEAT_STEP      = 1,
    parameter int COOL_DIV       = 4,
    parameter int MIN_HEAT_LEVEL = 100,
    parameter int SPIN_THRESH    = 8,
    parameter int RAMP_TICKS     = 3,
    parameter int DOOR_TICKS     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       water_valve,
    input  logic       heater,
    input  logic       drain_pump,
    input  logic [3:0] drum_motor,
    input  logic       door_lock,
    input  logic       imbalance_load,
    input  logic       fault_no_water,
    input  logic       fault_clog,
    output logic [9:0] water_level_sensor,
    output logic [6:0] temperature_adc_sensor,
    output logic       vibration_sensor,
    output logic       door_locked,
    output logic       overflow_flag,
    output logic       dry_heat_flag
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (COOL_DIV > 1) ? $clog2(COOL_DIV) : 1;
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);

    localparam logic [TW-1:0]     TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0]     COOL_LAST  = CW'(COOL_DIV - 1);
    localparam logic [RW-1:0]     RAMP_LAST  = RW'(RAMP_TICKS - 1);
    localparam logic [DW-1:0]     DOOR_LAST  = DW'(DOOR_TICKS - 1);
    localparam logic signed [11:0] FILL_S    = 12'(FILL_RATE);
    localparam logic signed [11:0] DRAIN_S   = 12'(DRAIN_RATE);
    localparam logic signed [11:0] MAX_S     = 12'(LEVEL_MAX);
    localparam logic [9:0]        LEVEL_MAX_V = 10'(LEVEL_MAX);
    localparam logic [9:0]        MIN_LVL_V   = 10'(MIN_HEAT_LEVEL);
    localparam logic [6:0]        AMBIENT_V   = 7'(AMBIENT_TEMP);
    localparam logic [7:0]        HEAT_V      = 8'(HEAT_STEP);
    localparam logic [3:0]        SPIN_V      = 4'(SPIN_THRESH);

    typedef enum logic [1:0] {V_IDLE, V_RAMP, V_SHAKE} vib_state_t;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [9:0]    level, level_nxt;
    logic [6:0]    temp, temp_nxt;
    logic [CW-1:0] cool_cnt, cool_nxt;
    logic [RW-1:0] ramp_cnt, ramp_nxt;
    logic [DW-1:0] door_cnt, door_cnt_nxt;
    logic          door_q, door_nxt;
    logic          vib_q, vib_nxt;
    logic          ovf_q, dry_q;
    vib_state_t    vstate, vstate_nxt;

    logic signed [11:0] inflow, outflow, level_sum;
    logic [7:0]         heat_sum;
    logic               heat_ok, spinning;

    assign tick = (tick_cnt == TICK_LAST);

    // Tub level: signed net flow, then clamp so the level never wraps.
    always_comb begin
        inflow    = (water_valve && !fault_no_water) ? FILL_S  : 12'sd0;
        outflow   = (drain_pump  && !fault_clog)     ? DRAIN_S : 12'sd0;
        level_sum = $signed({2'b00, level}) + inflow - outflow;
        level_nxt = level_sum[9:0];
        if (level_sum < 12'sd0) begin
            level_nxt = '0;
        end else if (level_sum > MAX_S) begin
            level_nxt = LEVEL_MAX_V;
        end
    end

    // Temperature: heat only when the element is submerged; otherwise drift
    // one degree toward ambient every COOL_DIV ticks.
    always_comb begin
        heat_ok  = heater && (level >= MIN_LVL_V);
        heat_sum = {1'b0, temp} + HEAT_V;
        temp_nxt = temp;
        cool_nxt = cool_cnt;
        if (heat_ok) begin
            temp_nxt = (heat_sum > 8'd127) ? 7'd127 : heat_sum[6:0];
            cool_nxt = '0;
        end else if (cool_cnt == COOL_LAST) begin
            cool_nxt = '0;
            if (temp > AMBIENT_V) begin
                temp_nxt = temp - 7'd1;
            end else if (temp < AMBIENT_V) begin
                temp_nxt = temp + 7'd1;
            end
        end else begin
            cool_nxt = cool_cnt + 1'b1;
        end
    end

    // Vibration FSM: an unbalanced load must spin for RAMP_TICKS ticks before shaking.
    always_comb begin
        spinning   = (drum_motor >= SPIN_V) && imbalance_load;
        vstate_nxt = vstate;
        ramp_nxt   = ramp_cnt;
        case (vstate)
            V_IDLE: begin
                if (spinning) begin
                    vstate_nxt = V_RAMP;
                    ramp_nxt   = RW'(1);
                end
            end
            V_RAMP: begin
                if (!spinning) begin
                    vstate_nxt = V_IDLE;
                    ramp_nxt   = '0;
                end else if (ramp_cnt == RAMP_LAST) begin
                    vstate_nxt = V_SHAKE;
                    ramp_nxt   = '0;
                end else begin
                    ramp_nxt = ramp_cnt + 1'b1;
                end
            end
            V_SHAKE: begin
                if (!spinning) begin
                    vstate_nxt = V_IDLE;
                end
            end
            default: begin
                vstate_nxt = V_IDLE;
                ramp_nxt   = '0;
            end
        endcase
        vib_nxt = (vstate_nxt == V_SHAKE);
    end

    // Door: a command must hold for DOOR_TICKS ticks; a revert clears progress.
    always_comb begin
        door_nxt     = door_q;
        door_cnt_nxt = '0;
        if (door_lock != door_q) begin
            if (door_cnt == DOOR_LAST) begin
                door_nxt = door_lock;
            end else begin
                door_cnt_nxt = door_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            level    <= '0;
            temp     <= AMBIENT_V;
            cool_cnt <= '0;
            ramp_cnt <= '0;
            vstate   <= V_IDLE;
            vib_q    <= 1'b0;
            door_cnt <= '0;
            door_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dry_q    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                level    <= level_nxt;
                temp     <= temp_nxt;
                cool_cnt <= cool_nxt;
                ramp_cnt <= ramp_nxt;
                vstate   <= vstate_nxt;
                vib_q    <= vib_nxt;
                door_cnt <= door_cnt_nxt;
                door_q   <= door_nxt;
                if (water_valve && (level == LEVEL_MAX_V)) begin
                    ovf_q <= 1'b1;
                end
                if (heater && (level < MIN_LVL_V)) begin
                    dry_q <= 1'b1;
                end
            end
        end
    end

`ifdef PLANT_NOISE_EN
    // Sensor dither only; all plant decisions use the clean internal level.
    logic [7:0] lfsr, lfsr_nxt;
    logic [9:0] sensor_q, sensor_nxt;

    always_comb begin
        lfsr_nxt   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        sensor_nxt = level_nxt;
        case (lfsr_nxt[1:0])
            2'b00:   sensor_nxt = (level_nxt == 10'd0) ? 10'd0 : level_nxt - 10'd1;
            2'b11:   sensor_nxt = (level_nxt >= LEVEL_MAX_V) ? LEVEL_MAX_V : level_nxt + 10'd1;
            default: sensor_nxt = level_nxt;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr     <= 8'hA5;
            sensor_q <= '0;
        end else if (tick) begin
            lfsr     <= lfsr_nxt;
            sensor_q <= sensor_nxt;
        end
    end

    assign water_level_sensor = sensor_q;
`else
    assign water_level_sensor = level;
`endif

    assign temperature_adc_sensor = temp;
    assign vibration_sensor       = vib_q;
    assign door_locked            = door_q;
    assign overflow_flag          = ovf_q;
    assign dry_heat_flag          = dry_q;

endmodule
